mux_scan_n: RTL and testbench
=============================

// Module: mux_scan_n
// PURPOSE
//  Parametrised N-channel, WIDTH-bit multiplexer with a registered output and valid/ready handshakes.
//  Generalises the 4:1 combinational mux to a sequential channel selector.
//  Two selection modes: manual (external select) and scan (round-robin over requesting channels).
//  Sits between several producer channels and one consumer in datapath exercises.
// PARAMETERS
//  WIDTH  8                Data width per channel (>=1)
//  NCH    4                Number of input channels (>=2, need not be a power of two)
//  SELW   $clog2(NCH)      Select/channel-index width (derived; do not override)
// PORTS
//  clk        in   1           Rising-edge clock, single clock domain
//  reset_n    in   1           Asynchronous reset, active low
//  mode       in   1           0 = manual select, 1 = round-robin scan
//  sel        in   SELW        Channel index used in manual mode
//  in_data    in   NCH*WIDTH   Channel k data in bits [k*WIDTH +: WIDTH]
//  in_valid   in   NCH         Channel k offers data
//  in_ready   out  NCH         One-hot (or zero); channel k data accepted this cycle
//  out_data   out  WIDTH       Registered selected data
//  out_ch     out  SELW        Index of the channel that produced out_data
//  out_valid  out  1           out_data/out_ch hold an unconsumed word
//  out_ready  in   1           Consumer accepts the word this cycle
//  stall_cnt  out  16          Only present with MUX_STALL_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous):
//    out_data=0, out_ch=0, out_valid=0, scan pointer ptr=0, stall_cnt=0.
//    in_ready is forced to 0 while reset is asserted.
//  - load = !out_valid || out_ready. The output register accepts a new word only when load=1.
//  - Manual mode: candidate = sel.
//    Accept if load && sel<NCH && in_valid[sel].
//    sel>=NCH: nothing is accepted and in_ready=0.
//  - Scan mode: candidate = first k with in_valid[k]=1, searching ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1.
//    Accept if load and a candidate exists.
//    On accept, ptr <= (k==NCH-1) ? 0 : k+1 (wrap-around).
//    No candidate: nothing is accepted and ptr is held.
//  - ptr advances only in scan mode; manual mode leaves it unchanged.
//  - On accept:
//    in_ready[k]=1 combinationally in the same cycle.
//    Next edge: out_data <= channel k data, out_ch <= k, out_valid <= 1.
//    Latency 1 cycle, input to output.
//  - Consume without new accept (out_valid && out_ready, no candidate): out_valid <= 0.
//    out_data/out_ch keep their last value.
//  - Simultaneous consume + accept: the new word is loaded back-to-back, so out_valid stays 1.
//    Full throughput is 1 word/cycle.
//  - Stall (out_valid && !out_ready): out_data/out_ch/out_valid are held stable.
//    in_ready=0 on all channels.
//  - mode/sel changes take effect in the cycle they are applied; a word already registered is never altered.
//  - in_ready is a function of the current-cycle inputs only; at most one bit is set.
// CONFIGURATION
//  MUX_STALL_CNT_EN defined:
//    Port stall_cnt[15:0] exists.
//    Increments each cycle with out_valid && !out_ready, saturates at 16'hFFFF.
//    Cleared only by reset.
//  MUX_STALL_CNT_EN undefined:
//    Port and counter are absent; behaviour is otherwise identical.
// TESTING
//  1 Reset: reset_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, in_ready=0 immediately, without waiting for a clk edge.
//  2 Manual: mode=0, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1
//    -> in_ready=4'b0100; next cycle out_data=A5, out_ch=2, out_valid=1.
//  3 Manual out-of-range: NCH=3, sel=3, in_valid=3'b111 -> in_ready=0, out_valid stays 0.
//  4 Scan fairness: mode=1, in_valid=4'b1011 held, out_ready=1 -> out_ch sequence 0,1,3,0,1,3, one word/cycle.
//  5 Stall: out_ready=0 for 5 cycles while out_valid=1 -> out_data unchanged, in_ready=0;
//    with MUX_STALL_CNT_EN, stall_cnt=5.
//  6 Wrap/empty: mode=1, ptr=3, in_valid=4'b0000 -> no accept, ptr holds 3;
//    then in_valid=4'b0001 -> ch0 accepted, ptr becomes 1.

Source files
------------

// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with valid/ready handshakes, manual or round-robin scan selection.
// Optional stall counter port stall_cnt is enabled by defining MUX_STALL_CNT_EN.
module mux_scan_n #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MUX_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);

  logic [SELW-1:0]  r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic             r_out_valid;

  logic             w_load;
  logic             w_scan_hit;
  logic [SELW-1:0]  w_scan_idx;
  logic [31:0]      w_pos;
  logic             w_pos_valid;
  logic             w_sel_valid;
  logic [SELW-1:0]  w_cand;
  logic             w_has;
  logic             w_accept;
  logic [WIDTH-1:0] w_cand_data;
  logic [SELW-1:0]  w_ptr_next;

  // Round-robin search: first requesting channel starting at r_ptr, wrapping past NCH-1.
  always_comb begin
    w_scan_hit  = 1'b0;
    w_scan_idx  = {SELW{1'b0}};
    w_pos       = 32'd0;
    w_pos_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_pos = 32'(r_ptr) + 32'(i);
      if (w_pos >= 32'(NCH)) begin
        w_pos = w_pos - 32'(NCH);
      end else begin
        w_pos = w_pos;
      end
      w_pos_valid = 1'(in_valid >> w_pos);
      if (!w_scan_hit && w_pos_valid) begin
        w_scan_hit = 1'b1;
        w_scan_idx = w_pos[SELW-1:0];
      end else begin
        w_scan_hit = w_scan_hit;
      end
    end
  end

  assign w_sel_valid = (32'(sel) < 32'(NCH)) && 1'(in_valid >> sel);

  // Candidate channel for the current cycle depending on selection mode.
  always_comb begin
    w_cand = {SELW{1'b0}};
    w_has  = 1'b0;
    case (mode)
      1'b0: begin
        w_cand = sel;
        w_has  = w_sel_valid;
      end
      1'b1: begin
        w_cand = w_scan_idx;
        w_has  = w_scan_hit;
      end
      default: begin
        w_cand = {SELW{1'b0}};
        w_has  = 1'b0;
      end
    endcase
  end

  assign w_load      = !r_out_valid || out_ready;
  assign w_accept    = reset_n && w_load && w_has;
  assign w_cand_data = WIDTH'(in_data >> (32'(w_cand) * 32'(WIDTH)));
  assign w_ptr_next  = (32'(w_cand) == 32'(NCH - 1)) ? {SELW{1'b0}} : (w_cand + SELW'(1));
  assign in_ready    = w_accept ? (ONE_HOT0 << w_cand) : {NCH{1'b0}};

  // Output word register and scan pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= {WIDTH{1'b0}};
      r_out_ch    <= {SELW{1'b0}};
      r_out_valid <= 1'b0;
      r_ptr       <= {SELW{1'b0}};
    end else if (w_accept) begin
      r_out_data  <= w_cand_data;
      r_out_ch    <= w_cand;
      r_out_valid <= 1'b1;
      if (mode) begin
        r_ptr <= w_ptr_next;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

`ifdef MUX_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles where a held word is refused by the consumer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mux_scan_n.sv
// Self-checking bench for mux_scan_n: directed scenarios plus randomized traffic against a queue-free reference model.
module tb_mux_scan_n;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        mode4, ordy4, ov4;
  logic [1:0]  sel4, och4;
  logic [31:0] data4;
  logic [3:0]  valid4, ir4;
  logic [7:0]  od4;

  logic        mode3, ordy3, ov3;
  logic [1:0]  sel3, och3;
  logic [23:0] data3;
  logic [2:0]  valid3, ir3;
  logic [7:0]  od3;

`ifdef MUX_STALL_CNT_EN
  logic [15:0] sc4, sc3;
`endif

  int          n_checks = 0;
  int          n_errors = 0;

  int          m_ptr, m_ch, m_stall;
  logic [7:0]  m_data;
  logic        m_valid;

  mux_scan_n #(.WIDTH(8), .NCH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .mode(mode4), .sel(sel4),
    .in_data(data4), .in_valid(valid4), .in_ready(ir4),
    .out_data(od4), .out_ch(och4), .out_valid(ov4), .out_ready(ordy4)
`ifdef MUX_STALL_CNT_EN
    , .stall_cnt(sc4)
`endif
  );

  mux_scan_n #(.WIDTH(8), .NCH(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .mode(mode3), .sel(sel3),
    .in_data(data3), .in_valid(valid3), .in_ready(ir3),
    .out_data(od3), .out_ch(och3), .out_valid(ov3), .out_ready(ordy3)
`ifdef MUX_STALL_CNT_EN
    , .stall_cnt(sc3)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference choice: which channel (or -1) is taken this cycle given current inputs and model state.
  function automatic int model_pick();
    int k;
    k = -1;
    if (!reset_n || (m_valid && !ordy4)) return -1;
    if (!mode4) begin
      if (valid4[sel4]) k = int'(sel4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (k < 0 && valid4[(m_ptr + i) % 4]) k = (m_ptr + i) % 4;
      end
    end
    return k;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_ch = 0; m_stall = 0; m_data = 8'h00; m_valid = 1'b0;
  endtask

  // One clock of dut4 checked against the model; entered and left at posedge+1.
  task automatic step4();
    int k;
    logic [3:0] er;
    #1;
    k  = model_pick();
    er = (k >= 0) ? (4'b0001 << k) : 4'b0000;
    check_eq("in_ready", 32'(ir4), 32'(er));
    if (m_valid && !ordy4 && m_stall < 65535) m_stall++;
    @(posedge clk); #1;
    if (k >= 0) begin
      m_data  = data4[k*8 +: 8];
      m_ch    = k;
      m_valid = 1'b1;
      if (mode4) m_ptr = (k + 1) % 4;
    end else if (ordy4) begin
      m_valid = 1'b0;
    end
    check_eq("out_valid", 32'(ov4), 32'(m_valid));
    check_eq("out_ch", 32'(och4), 32'(m_ch));
    check_eq("out_data", 32'(od4), 32'(m_data));
`ifdef MUX_STALL_CNT_EN
    check_eq("stall_cnt", 32'(sc4), 32'(m_stall));
`endif
  endtask

  task automatic do_reset();
    valid4 = 4'b0000; valid3 = 3'b000; ordy4 = 1'b1; ordy3 = 1'b1;
    mode4 = 1'b0; mode3 = 1'b0; sel4 = 2'd0; sel3 = 2'd3;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    int exp4[6];
    int exp3[4];
    logic [7:0] held;
    exp4 = '{0, 1, 3, 0, 1, 3};
    exp3 = '{0, 1, 2, 0};

    mode4 = 1'b0; sel4 = 2'd0; data4 = 32'hDEAD_BEEF; valid4 = 4'b1111; ordy4 = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; data3 = 24'h123456;    valid3 = 3'b111;  ordy3 = 1'b1;
    model_reset();

    #3;
    check_eq("rst_in_ready", 32'(ir4), 32'h0);
    check_eq("rst_out_valid", 32'(ov4), 32'h0);
    check_eq("rst_out_data", 32'(od4), 32'h0);
    check_eq("rst_out_ch", 32'(och4), 32'h0);
    check_eq("rst_in_ready3", 32'(ir3), 32'h0);
    valid4 = 4'b0000; valid3 = 3'b000; sel3 = 2'd3;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Manual selection of channel 2.
    mode4 = 1'b0; sel4 = 2'd2; valid4 = 4'b0100; data4 = 32'h00A5_0000; ordy4 = 1'b1;
    #1;
    check_eq("t2_in_ready", 32'(ir4), 32'h4);
    step4();
    check_eq("t2_out_data", 32'(od4), 32'hA5);
    check_eq("t2_out_ch", 32'(och4), 32'h2);
    check_eq("t2_out_valid", 32'(ov4), 32'h1);

    // Consumer stalls for five cycles while a word is held.
    held = od4;
    ordy4 = 1'b0; valid4 = 4'b1111; data4 = $urandom;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t5_in_ready", 32'(ir4), 32'h0);
      step4();
      check_eq("t5_hold", 32'(od4), 32'(held));
    end
`ifdef MUX_STALL_CNT_EN
    check_eq("t5_stall_cnt", 32'(sc4), 32'd5);
`endif
    ordy4 = 1'b1; valid4 = 4'b0000;
    step4();

    // Scan fairness with channel 2 idle.
    do_reset();
    mode4 = 1'b1; valid4 = 4'b1011; ordy4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data4 = $urandom;
      step4();
      check_eq("t4_out_ch", 32'(och4), 32'(exp4[i]));
      check_eq("t4_out_valid", 32'(ov4), 32'h1);
    end

    // Pointer parked at 3, empty cycle, then wrap to channel 0.
    do_reset();
    mode4 = 1'b1; ordy4 = 1'b1; valid4 = 4'b0100; data4 = $urandom;
    step4();
    valid4 = 4'b0000;
    #1;
    check_eq("t6_empty_rdy", 32'(ir4), 32'h0);
    step4();
    check_eq("t6_empty_valid", 32'(ov4), 32'h0);
    valid4 = 4'b0001;
    #1;
    check_eq("t6_wrap_rdy", 32'(ir4), 32'h1);
    step4();
    check_eq("t6_wrap_ch", 32'(och4), 32'h0);
    valid4 = 4'b1111;
    step4();
    check_eq("t6_ptr_after", 32'(och4), 32'h1);

    // Three-channel instance: out-of-range select, manual top channel, scan wrap.
    do_reset();
    mode3 = 1'b0; sel3 = 2'd3; valid3 = 3'b111; data3 = 24'hC3B2A1; ordy3 = 1'b1;
    #1;
    check_eq("t3_oor_rdy", 32'(ir3), 32'h0);
    @(posedge clk); #1;
    check_eq("t3_oor_valid", 32'(ov3), 32'h0);
    sel3 = 2'd2;
    #1;
    check_eq("t3_sel2_rdy", 32'(ir3), 32'h4);
    @(posedge clk); #1;
    check_eq("t3_sel2_data", 32'(od3), 32'hC3);
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("t3_scan_ch", 32'(och3), 32'(exp3[i]));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      mode4  = 1'($urandom_range(0, 1));
      sel4   = 2'($urandom_range(0, 3));
      valid4 = 4'($urandom);
      data4  = $urandom;
      ordy4  = ($urandom_range(0, 3) != 0);
      step4();
    end

    // Asynchronous reset in mid-cycle with a word held.
    mode4 = 1'b0; sel4 = 2'd0; valid4 = 4'b0001; data4 = 32'h0000_005A; ordy4 = 1'b0;
    step4();
    check_eq("t1_pre_valid", 32'(ov4), 32'h1);
    valid4 = 4'b1111; ordy4 = 1'b1;
    reset_n = 1'b0;
    #1;
    check_eq("t1_out_valid", 32'(ov4), 32'h0);
    check_eq("t1_out_data", 32'(od4), 32'h0);
    check_eq("t1_out_ch", 32'(och4), 32'h0);
    check_eq("t1_in_ready", 32'(ir4), 32'h0);
`ifdef MUX_STALL_CNT_EN
    check_eq("t1_stall_cnt", 32'(sc4), 32'h0);
`endif
    valid4 = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_eq("t1_after_valid", 32'(ov4), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
